// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: N shift/trial-subtract iterations produce
// an N-bit quotient and remainder. Companion to the shift-add multiplier.
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         Div_By_Zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r;
    logic [N:0]     a_r;
    logic [N-1:0]   q_r;
    logic [N-1:0]   m_r;
    logic [CW-1:0]  cnt_r;
    logic [N+1:0]   trial_s;
    logic [N:0]     a_next_s;
    logic [N-1:0]   q_next_s;

    // Trial subtraction; a clear borrow bit means the divisor fits and is committed.
    always_comb begin
        trial_s  = {1'b0, a_r} - {2'b00, m_r};
        a_next_s = a_r;
        q_next_s = q_r;
        if (trial_s[N+1] == 1'b0) begin
            a_next_s = trial_s[N:0];
            q_next_s = {q_r[N-1:1], 1'b1};
        end else begin
            a_next_s = a_r;
            q_next_s = {q_r[N-1:1], 1'b0};
        end
    end

    // Control FSM and datapath; results publish only on the completion edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            a_r         <= {(N+1){1'b0}};
            q_r         <= {N{1'b0}};
            m_r         <= {N{1'b0}};
            cnt_r       <= CNT_ZERO;
            Quotient    <= {N{1'b0}};
            Remainder   <= {N{1'b0}};
            Div_By_Zero <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        a_r     <= {(N+1){1'b0}};
                        q_r     <= Dividend;
                        m_r     <= Divisor;
                        cnt_r   <= CNT_ZERO;
                        state_r <= SHIFT;
                        Busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    {a_r, q_r} <= {a_r[N-1:0], q_r, 1'b0};
                    state_r    <= SUB;
                end
                SUB: begin
                    a_r   <= a_next_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DONE;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        Quotient    <= q_next_s;
                        Remainder   <= a_next_s[N-1:0];
                        Div_By_Zero <= (m_r == {N{1'b0}});
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    // Start must drop before another operation can be accepted.
                    if (!Start) begin
                        state_r <= IDLE;
                        Done    <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: scoreboard of expected results,
// checked when Done rises, plus latency, hold, reset-abort and stability checks.
module tb_shift_sub_divider;

    typedef struct {
        logic [7:0] dd;
        logic [7:0] ds;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] Dividend = 8'd0;
    logic [7:0] Divisor = 8'd0;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       Div_By_Zero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    shift_sub_divider #(.N(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Dividend(Dividend), .Divisor(Divisor),
        .Quotient(Quotient), .Remainder(Remainder),
        .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero)
    );

    always #5 Clk = ~Clk;

    // Push the reference result for one operation.
    task automatic push_exp(input logic [7:0] dd, input logic [7:0] ds);
        exp_t e;
        e.dd = dd;
        e.ds = ds;
        if (ds == 8'd0) begin
            e.q = 8'hFF;
            e.r = dd;
            e.dbz = 1'b1;
        end else begin
            e.q = dd / ds;
            e.r = dd % ds;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // One complete operation. hold: keep Start high for 40 cycles total.
    // chg: alter Dividend to 3 while Busy.
    task automatic do_op(input logic [7:0] dd, input logic [7:0] ds,
                         input bit hold, input bit chg, input string tag);
        int busy_cnt;
        bit unstable;
        logic [7:0] prev_q;
        logic [7:0] prev_r;
        int elapsed;
        exp_t e;
        push_exp(dd, ds);
        @(negedge Clk);
        prev_q = Quotient;
        prev_r = Remainder;
        Dividend = dd;
        Divisor = ds;
        Start = 1'b1;
        @(negedge Clk);
        elapsed = 1;
        if (!hold) Start = 1'b0;
        busy_cnt = 0;
        unstable = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (Done) break;
            if (Busy) begin
                busy_cnt++;
                if (busy_cnt == 2 && chg) Dividend = 8'd3;
                if (Quotient !== prev_q || Remainder !== prev_r) unstable = 1'b1;
            end
            @(negedge Clk);
            elapsed++;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: Done=%b required 1", tag, Done);
        end
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required 16", tag, busy_cnt);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL %s stable_during_busy: outputs changed while Busy, required stable %0h/%0h",
                     tag, prev_q, prev_r);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: got 0 entries required 1", tag);
        end else begin
            e = sb.pop_front();
            if (Quotient !== e.q || Remainder !== e.r || Div_By_Zero !== e.dbz) begin
                errors++;
                $display("FAIL %s result %0d/%0d: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                         tag, e.dd, e.ds, Quotient, Remainder, Div_By_Zero, e.q, e.r, e.dbz);
            end
            if (e.ds != 8'd0) begin
                checks++;
                if ((int'(Quotient) * int'(e.ds) + int'(Remainder)) != int'(e.dd) || Remainder >= e.ds) begin
                    errors++;
                    $display("FAIL %s invariant %0d/%0d: got q=%0d r=%0d required q*d+r=%0d and r<d",
                             tag, e.dd, e.ds, Quotient, Remainder, e.dd);
                end
            end
        end
        if (hold) begin
            unstable = 1'b0;
            while (elapsed < 40) begin
                @(negedge Clk);
                elapsed++;
                if (Done !== 1'b1 || Busy !== 1'b0) unstable = 1'b1;
            end
            checks++;
            if (unstable) begin
                errors++;
                $display("FAIL %s hold_done: Done dropped or second op started, required Done=1 Busy=0", tag);
            end
            Start = 1'b0;
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s return_idle: got Done=%b Busy=%b required 0 0", tag, Done, Busy);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (Quotient !== 8'd0 || Remainder !== 8'd0 || Busy !== 1'b0 ||
            Done !== 1'b0 || Div_By_Zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got q=%0h r=%0h busy=%b done=%b dbz=%b required all 0",
                     Quotient, Remainder, Busy, Done, Div_By_Zero);
        end
    endtask

    task automatic test_basic();
        do_op(8'd100, 8'd7, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_edges();
        do_op(8'd255, 8'd1, 1'b0, 1'b0, "edge_255_1");
        do_op(8'd7, 8'd100, 1'b0, 1'b0, "edge_7_100");
        do_op(8'd255, 8'd255, 1'b0, 1'b0, "edge_255_255");
        do_op(8'd0, 8'd9, 1'b0, 1'b0, "edge_0_9");
    endtask

    task automatic test_div_zero();
        do_op(8'd200, 8'd0, 1'b0, 1'b0, "dbz_200_0");
        do_op(8'd50, 8'd5, 1'b0, 1'b0, "after_dbz_50_5");
    endtask

    task automatic test_hold_start();
        do_op(8'd100, 8'd7, 1'b1, 1'b1, "hold_start");
    endtask

    task automatic test_reset_mid();
        int busy_cnt;
        @(negedge Clk);
        Dividend = 8'd200;
        Divisor = 8'd3;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (Busy) busy_cnt++;
            if (busy_cnt == 5) break;
            @(negedge Clk);
        end
        Reset_n = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Quotient !== 8'd0 || Remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b q=%0d r=%0d required 0 0 0 0",
                     Busy, Done, Quotient, Remainder);
        end
        Reset_n = 1'b1;
        do_op(8'd200, 8'd3, 1'b0, 1'b0, "after_reset_200_3");
    endtask

    task automatic test_random();
        logic [7:0] dd;
        logic [7:0] ds;
        for (int i = 0; i < 500; i++) begin
            dd = 8'($urandom_range(0, 255));
            ds = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_op(dd, ds, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_hold_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse datapath of the lab's shift-add multiplier.
- Each iteration shifts the {A,Q} register pair left by one, trial-subtracts the divisor from A, then either commits the difference or restores A.
- Sits beside the multiplier in the lab datapath and is driven by the same switch/Run-style top-level control.
- Produces an N-bit quotient and remainder after N shift/subtract iterations.

Parameters:
- N, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Start  input  1  level request; accepted in IDLE when high.
- Dividend  input  N  unsigned dividend; sampled only at accept.
- Divisor  input  N  unsigned divisor; sampled only at accept.
- Quotient  output  N  registered quotient of the last completed operation.
- Remainder  output  N  registered remainder of the last completed operation.
- Busy  output  1  high in SHIFT and SUB states.
- Done  output  1  high in the DONE state.
- Div_By_Zero  output  1  registered; high when the last completed operation had Divisor==0.

Behaviour:
- Reset: Reset_n low at a rising edge forces IDLE and clears A, Q, M, the counter, Quotient, Remainder and Div_By_Zero. Busy=0 and Done=0 follow from the state. Reset overrides every other event, including mid-operation; no partial result is published.
- Internal registers: A is N+1 bits (partial remainder; holds up to 2*M-1 after a shift). Q is N bits (dividend shifting out, quotient shifting in). M is N bits. cnt is clog2(N) bits.
- IDLE: when Start=1, load A=0, Q=Dividend, M=Divisor, cnt=0, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT: {A,Q} <= {A,Q} << 1 (A[N] receives A[N-1], Q[0] receives 0), then go to SUB.
- SUB: form trial = {1'b0,A} - {2'b0,M} with N+2 bits.
  - If trial[N+1]==0: A <= trial[N:0] and Q[0] <= 1.
  - Otherwise: A is unchanged and Q[0] stays 0.
  - Then cnt <= cnt+1.
  - If cnt==N-1, go to DONE and, on the same edge, load Quotient <= final Q, Remainder <= final A[N-1:0], Div_By_Zero <= (M==0). Otherwise go to SHIFT.
- Latency: Start accepted on edge E0; Busy is high for exactly 2N cycles (16 for N=8); Done rises after edge E0+2N.
- DONE: hold while Start=1; go to IDLE on the first edge with Start=0. A Start held high across completion never triggers a second operation; the requester must drop Start and raise it again.
- Quotient, Remainder and Div_By_Zero change only on the completion edge or on reset. They stay stable throughout Busy and through later IDLE periods.
- Dividend and Divisor changes while Busy or in DONE are ignored.
- Divide by zero: no special datapath. With M=0 every trial succeeds, so Quotient ends at all-ones and Remainder ends equal to Dividend. Div_By_Zero=1 flags the case.
- Invariant at completion when M!=0: Quotient*Divisor + Remainder == Dividend and Remainder < Divisor. A never exceeds 2*M-1, so A[N] is 0 after every SUB.

Test Plan:
1. Reset_n=0 for 2 cycles, then release -> Quotient=0, Remainder=0, Busy=0, Done=0, Div_By_Zero=0. Then Start=1 with Dividend=100, Divisor=7 -> Busy for 16 cycles, then Done=1 with Quotient=14, Remainder=2, Div_By_Zero=0.
2. Edge operands, Start toggled between each: 255/1 -> Q=255, R=0. 7/100 -> Q=0, R=7. 255/255 -> Q=1, R=0. 0/9 -> Q=0, R=0.
3. Divide by zero: 200/0 -> Q=0xFF, R=200, Div_By_Zero=1. A following 50/5 -> Q=10, R=0, Div_By_Zero=0.
4. Start held high for 40 cycles on 100/7 -> exactly one operation with 16 Busy cycles; Done stays high until Start=0; IDLE one edge after Start drops. Change Dividend to 3 while Busy -> result still 14 r 2.
5. Start 200/3, then pull Reset_n low on the 5th Busy cycle -> next edge gives IDLE, Busy=0, Quotient=0, Remainder=0. A fresh 200/3 after release -> Q=66, R=2.
6. Random sweep of 500 operand pairs against the invariant and a reference model (Divisor=0 checked against the all-ones rule). Throughout, Quotient and Remainder must not change during any Busy cycle.
